// File: rtl/cmos_sccb_init.sv
// rtl/cmos_sccb_init.sv - CMOS sensor power-up sequencer and write-only SCCB table master
// Holds the sensor in reset, lets it settle, then writes each {reg,val} table entry over SIO_C/SIO_D.
module cmos_sccb_init #(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          SCCB_HZ    = 100_000,
  parameter logic [7:0]  DEV_ADDR   = 8'h42,
  parameter int          NUM_REGS   = 64,
  parameter int          RST_CYC    = 50_000,
  parameter int          SETTLE_CYC = 50_000,
  localparam int         IW         = $clog2(NUM_REGS)
) (
  input  logic          CLK_IN,
  input  logic          nRST,
  input  logic          start,
  output logic [IW-1:0] tbl_idx,
  input  logic [15:0]   tbl_data,
  output logic          CMOS_SIO_C,
  output logic          CMOS_SIO_D,
  output logic          CMOS_RESET,
  output logic          CMOS_PWDN,
  output logic          cfg_busy,
  output logic          cfg_done
);

  localparam int TICK_DIV = CLK_HZ / (4 * SCCB_HZ);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DLY_MAX  = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int DW       = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

  typedef enum logic [2:0] {
    S_RST_HOLD, S_SETTLE, S_LOAD, S_START, S_BITS, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_tick_cnt, w_tick_nxt;
  logic [1:0]      r_q, w_q_nxt;
  logic [4:0]      r_bit, w_bit_nxt;
  logic [DW-1:0]   r_dly, w_dly_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [26:0]     r_frame, w_frame_nxt;
  logic            r_sio_c, r_sio_d, r_cmos_reset, r_busy, r_done;
  logic            w_sio_c_nxt, w_sio_d_nxt;
  logic            w_tick, w_slot_end, w_bit_val;

  assign w_tick     = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_slot_end = w_tick && (r_q == 2'd3);

  // Outputs are registered from next-state values so the bus pins come straight from flops.
  always_ff @(posedge CLK_IN or negedge nRST) begin
    if (!nRST) begin
      r_state      <= S_RST_HOLD;
      r_tick_cnt   <= '0;
      r_q          <= '0;
      r_bit        <= '0;
      r_dly        <= '0;
      r_idx        <= '0;
      r_frame      <= '0;
      r_sio_c      <= 1'b1;
      r_sio_d      <= 1'b1;
      r_cmos_reset <= 1'b0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_nxt;
      r_q          <= w_q_nxt;
      r_bit        <= w_bit_nxt;
      r_dly        <= w_dly_nxt;
      r_idx        <= w_idx_nxt;
      r_frame      <= w_frame_nxt;
      r_sio_c      <= w_sio_c_nxt;
      r_sio_d      <= w_sio_d_nxt;
      r_cmos_reset <= (w_state_nxt != S_RST_HOLD);
      r_busy       <= (w_state_nxt != S_DONE);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  // LOAD shares the tick counter so that it counts as the first cycle of the START slot.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = '0;
    w_q_nxt     = r_q;
    w_bit_nxt   = r_bit;
    w_dly_nxt   = r_dly;
    w_idx_nxt   = r_idx;
    w_frame_nxt = r_frame;
    if (r_state inside {S_LOAD, S_START, S_BITS, S_STOP, S_GAP})
      w_tick_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
    if ((r_state inside {S_START, S_BITS, S_STOP, S_GAP}) && w_tick)
      w_q_nxt = r_q + 2'd1;
    case (r_state)
      S_RST_HOLD: begin
        if (r_dly == DW'(RST_CYC - 1)) begin
          w_state_nxt = S_SETTLE;
          w_dly_nxt   = '0;
        end else begin
          w_dly_nxt = r_dly + 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_dly == DW'(SETTLE_CYC - 1)) begin
          w_state_nxt = S_LOAD;
          w_dly_nxt   = '0;
        end else begin
          w_dly_nxt = r_dly + 1'b1;
        end
      end
      S_LOAD: begin
        if (tbl_data == 16'hFFFF) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_START;
          w_q_nxt     = 2'd0;
          w_frame_nxt = {DEV_ADDR, 1'b1, tbl_data[15:8], 1'b1, tbl_data[7:0], 1'b1};
        end
      end
      S_START: begin
        if (w_slot_end) begin
          w_state_nxt = S_BITS;
          w_bit_nxt   = 5'd0;
        end
      end
      S_BITS: begin
        if (w_slot_end) begin
          if (r_bit == 5'd26) w_state_nxt = S_STOP;
          else                w_bit_nxt   = r_bit + 5'd1;
        end
      end
      S_STOP: begin
        if (w_slot_end) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_slot_end) begin
          if (r_idx == IW'(NUM_REGS - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_RST_HOLD;
    endcase
  end

  assign w_bit_val = r_frame[5'd26 - w_bit_nxt];

  always_comb begin
    w_sio_c_nxt = 1'b1;
    w_sio_d_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_sio_d_nxt = ~w_q_nxt[1];
      S_BITS: begin
        w_sio_c_nxt = w_q_nxt[1];
        w_sio_d_nxt = w_bit_val;
      end
      S_STOP: begin
        w_sio_c_nxt = w_q_nxt[1];
        w_sio_d_nxt = (w_q_nxt == 2'd3);
      end
      default: begin
        w_sio_c_nxt = 1'b1;
        w_sio_d_nxt = 1'b1;
      end
    endcase
  end

  assign tbl_idx    = r_idx;
  assign CMOS_SIO_C = r_sio_c;
  assign CMOS_SIO_D = r_sio_d;
  assign CMOS_RESET = r_cmos_reset;
  assign CMOS_PWDN  = 1'b0;
  assign cfg_busy   = r_busy;
  assign cfg_done   = r_done;

endmodule

// File: tb/tb_cmos_sccb_init.sv
// tb/tb_cmos_sccb_init.sv - directed bench for cmos_sccb_init with an SCCB bus decoder
module tb_cmos_sccb_init;

  logic        CLK_IN = 1'b0;
  logic        nRST   = 1'b0;
  logic        start  = 1'b0;
  logic [1:0]  tbl_idx;
  logic [15:0] tbl_data;
  logic        sio_c, sio_d, cmos_reset, cmos_pwdn, cfg_busy, cfg_done;
  logic [15:0] tbl [0:3];
  logic [26:0] exp_f [0:3];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int base = 0;
  int proto_err = 0;
  int c_edges = 0;
  int rst_low_cyc = 0;
  int nbits = 0;
  logic prev_c = 1'b1;
  logic prev_d = 1'b1;
  logic in_frame = 1'b0;
  logic [26:0] shreg = '0;
  logic [26:0] frames[$];
  int starts[$];

  assign tbl_data = tbl[tbl_idx];

  cmos_sccb_init #(
    .CLK_HZ(4_000_000), .SCCB_HZ(100_000), .DEV_ADDR(8'h42),
    .NUM_REGS(4), .RST_CYC(100), .SETTLE_CYC(100)
  ) dut (
    .CLK_IN(CLK_IN), .nRST(nRST), .start(start), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .CMOS_SIO_C(sio_c), .CMOS_SIO_D(sio_d), .CMOS_RESET(cmos_reset), .CMOS_PWDN(cmos_pwdn),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  always #5 CLK_IN = ~CLK_IN;
  always @(posedge CLK_IN) cyc <= cyc + 1;

  // Bus decoder: START/STOP are SIO_D edges while SIO_C is high; any such edge mid-frame is an error.
  always @(negedge CLK_IN) begin
    if (nRST && !cmos_reset) rst_low_cyc <= rst_low_cyc + 1;
    if (!nRST) begin
      in_frame <= 1'b0;
      nbits    <= 0;
      prev_c   <= 1'b1;
      prev_d   <= 1'b1;
    end else begin
      if (prev_c != sio_c) c_edges <= c_edges + 1;
      if (prev_c && sio_c && prev_d && !sio_d) begin
        if (in_frame) proto_err <= proto_err + 1;
        in_frame <= 1'b1;
        nbits    <= 0;
        shreg    <= '0;
        starts.push_back(cyc - base);
      end else if (prev_c && sio_c && !prev_d && sio_d) begin
        if (in_frame && nbits == 27) frames.push_back(shreg);
        else proto_err <= proto_err + 1;
        in_frame <= 1'b0;
      end else if (!prev_c && sio_c) begin
        if (!in_frame) proto_err <= proto_err + 1;
        else if (nbits < 27) begin
          shreg <= {shreg[25:0], sio_d};
          nbits <= nbits + 1;
        end
      end
      prev_c <= sio_c;
      prev_d <= sio_d;
    end
  end

  task automatic release_rst();
    @(negedge CLK_IN);
    nRST = 1'b1;
    base = cyc;
    frames.delete();
    starts.delete();
  endtask

  task automatic wait_done(input int exp_rel, input string name);
    int i;
    i = 0;
    while (!cfg_done && i < 8000) begin
      @(negedge CLK_IN);
      i++;
    end
    n_cmp++;
    if (cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_timeout: cfg_done=%b after %0d cycles, want 1", name, cfg_done, i);
    end else begin
      n_cmp++;
      if (cyc - base != exp_rel) begin
        n_fail++;
        $display("FAIL %s_done_time: got %0d want %0d", name, cyc - base, exp_rel);
      end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(posedge CLK_IN);
    #1;
    n_cmp++; if (sio_c !== 1'b1) begin n_fail++; $display("FAIL reset_sio_c: got %b want 1", sio_c); end
    n_cmp++; if (sio_d !== 1'b1) begin n_fail++; $display("FAIL reset_sio_d: got %b want 1", sio_d); end
    n_cmp++; if (cmos_reset !== 1'b0) begin n_fail++; $display("FAIL reset_cmos_reset: got %b want 0", cmos_reset); end
    n_cmp++; if (cmos_pwdn !== 1'b0) begin n_fail++; $display("FAIL reset_pwdn: got %b want 0", cmos_pwdn); end
    n_cmp++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", cfg_busy); end
    n_cmp++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", cfg_done); end
    n_cmp++; if (tbl_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", tbl_idx); end
  endtask

  task automatic test_powerup();
    release_rst();
    for (int k = 1; k <= 220; k++) begin
      @(posedge CLK_IN);
      #1;
      if (k == 99) begin
        n_cmp++; if (cmos_reset !== 1'b0) begin n_fail++; $display("FAIL pwr_reset_99: got %b want 0", cmos_reset); end
      end
      if (k == 100) begin
        n_cmp++; if (cmos_reset !== 1'b1) begin n_fail++; $display("FAIL pwr_reset_100: got %b want 1", cmos_reset); end
      end
      if (k == 219) begin
        n_cmp++; if (sio_d !== 1'b1) begin n_fail++; $display("FAIL pwr_sio_d_219: got %b want 1", sio_d); end
      end
      if (k == 220) begin
        n_cmp++; if (sio_d !== 1'b0) begin n_fail++; $display("FAIL pwr_sio_d_220: got %b want 0", sio_d); end
        n_cmp++; if (sio_c !== 1'b1) begin n_fail++; $display("FAIL pwr_sio_c_220: got %b want 1", sio_c); end
      end
    end
  endtask

  task automatic test_table();
    wait_done(5000, "table");
    n_cmp++; if (frames.size() != 4) begin n_fail++; $display("FAIL table_count: got %0d want 4", frames.size()); end
    for (int i = 0; i < 4 && i < frames.size(); i++) begin
      n_cmp++;
      if (frames[i] !== exp_f[i]) begin n_fail++; $display("FAIL table_frame%0d: got %h want %h", i, frames[i], exp_f[i]); end
    end
    n_cmp++; if (starts.size() > 0 && starts[0] != 220) begin n_fail++; $display("FAIL table_first_start: got %0d want 220", starts[0]); end
    for (int i = 1; i < starts.size(); i++) begin
      n_cmp++;
      if (starts[i] - starts[i-1] != 1200) begin n_fail++; $display("FAIL table_period%0d: got %0d want 1200", i, starts[i] - starts[i-1]); end
    end
    n_cmp++; if (tbl_idx !== 2'd3) begin n_fail++; $display("FAIL table_idx: got %0d want 3", tbl_idx); end
    n_cmp++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL table_busy: got %b want 0", cfg_busy); end
  endtask

  task automatic test_restart();
    int rl;
    rl = rst_low_cyc;
    @(negedge CLK_IN);
    start = 1'b1;
    base = cyc;
    frames.delete();
    starts.delete();
    @(negedge CLK_IN);
    start = 1'b0;
    n_cmp++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b want 1", cfg_busy); end
    n_cmp++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b want 0", cfg_done); end
    n_cmp++; if (tbl_idx !== 2'd0) begin n_fail++; $display("FAIL restart_idx: got %0d want 0", tbl_idx); end
    while (cyc - base < 2000) @(negedge CLK_IN);
    n_cmp++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL restart_done_mid: got %b want 0", cfg_done); end
    start = 1'b1;
    @(negedge CLK_IN);
    start = 1'b0;
    wait_done(4801, "restart");
    n_cmp++; if (frames.size() != 4) begin n_fail++; $display("FAIL restart_count: got %0d want 4", frames.size()); end
    n_cmp++; if (frames.size() == 4 && frames[3] !== exp_f[3]) begin n_fail++; $display("FAIL restart_frame3: got %h want %h", frames[3], exp_f[3]); end
    n_cmp++; if (starts.size() > 0 && starts[0] != 21) begin n_fail++; $display("FAIL restart_first_start: got %0d want 21", starts[0]); end
    n_cmp++; if (rst_low_cyc != rl) begin n_fail++; $display("FAIL restart_cmos_reset: low %0d cycles want 0", rst_low_cyc - rl); end
  endtask

  task automatic test_early_end();
    int ce;
    tbl[1] = 16'hFFFF;
    @(negedge CLK_IN);
    nRST = 1'b0;
    repeat (3) @(negedge CLK_IN);
    release_rst();
    wait_done(1401, "early");
    n_cmp++; if (frames.size() != 1) begin n_fail++; $display("FAIL early_count: got %0d want 1", frames.size()); end
    n_cmp++; if (frames.size() > 0 && frames[0] !== exp_f[0]) begin n_fail++; $display("FAIL early_frame0: got %h want %h", frames[0], exp_f[0]); end
    n_cmp++; if (tbl_idx !== 2'd1) begin n_fail++; $display("FAIL early_idx: got %0d want 1", tbl_idx); end
    ce = c_edges;
    repeat (300) @(negedge CLK_IN);
    n_cmp++; if (c_edges != ce) begin n_fail++; $display("FAIL early_sio_c_idle: got %0d edges want 0", c_edges - ce); end
    n_cmp++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL early_done_sticky: got %b want 1", cfg_done); end
  endtask

  task automatic test_reset_midbits();
    tbl[1] = 16'h1104;
    @(negedge CLK_IN);
    nRST = 1'b0;
    repeat (3) @(negedge CLK_IN);
    release_rst();
    repeat (3045) @(posedge CLK_IN);
    #2;
    n_cmp++; if (frames.size() != 2) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 2", frames.size()); end
    n_cmp++; if (sio_c !== 1'b0) begin n_fail++; $display("FAIL mid_pre_sio_c: got %b want 0", sio_c); end
    nRST = 1'b0;
    #1;
    n_cmp++; if (sio_c !== 1'b1) begin n_fail++; $display("FAIL mid_sio_c: got %b want 1", sio_c); end
    n_cmp++; if (sio_d !== 1'b1) begin n_fail++; $display("FAIL mid_sio_d: got %b want 1", sio_d); end
    n_cmp++; if (cmos_reset !== 1'b0) begin n_fail++; $display("FAIL mid_cmos_reset: got %b want 0", cmos_reset); end
    n_cmp++; if (tbl_idx !== 2'd0) begin n_fail++; $display("FAIL mid_idx: got %0d want 0", tbl_idx); end
    repeat (5) @(negedge CLK_IN);
    release_rst();
    wait_done(5000, "mid_rerun");
    n_cmp++; if (frames.size() != 4) begin n_fail++; $display("FAIL mid_rerun_count: got %0d want 4", frames.size()); end
    n_cmp++; if (frames.size() > 0 && frames[0] !== exp_f[0]) begin n_fail++; $display("FAIL mid_rerun_frame0: got %h want %h", frames[0], exp_f[0]); end
  endtask

  task automatic test_protocol();
    n_cmp++; if (proto_err != 0) begin n_fail++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
  endtask

  initial begin
    tbl[0] = 16'h1280; tbl[1] = 16'h1104; tbl[2] = 16'h3A04; tbl[3] = 16'h4000;
    exp_f[0] = {8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1};
    exp_f[1] = {8'h42, 1'b1, 8'h11, 1'b1, 8'h04, 1'b1};
    exp_f[2] = {8'h42, 1'b1, 8'h3A, 1'b1, 8'h04, 1'b1};
    exp_f[3] = {8'h42, 1'b1, 8'h40, 1'b1, 8'h00, 1'b1};
    test_reset();
    test_powerup();
    test_table();
    test_restart();
    test_early_end();
    test_reset_midbits();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
